// File: rtl/csr_counter_bank_pkg.sv
// Shared types and CSR address constants for the machine counter bank.
// Privilege encoding, counter container type and event-select width helper.
package csr_counter_bank_pkg;

   typedef enum logic [1:0] {
      PRIV_U = 2'd0,
      PRIV_S = 2'd1,
      PRIV_M = 2'd3
   } priv_e;

   typedef logic [63:0] csr_counter_t;

   localparam logic [11:0] CSR_MCYCLE           = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET         = 12'hB02;
   localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH          = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH        = 12'hB82;
   localparam logic [11:0] CSR_MHPMCOUNTERH_BASE = 12'hB80;
   localparam logic [11:0] CSR_CYCLE            = 12'hC00;
   localparam logic [11:0] CSR_TIME             = 12'hC01;
   localparam logic [11:0] CSR_INSTRET          = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH           = 12'hC80;
   localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;
   localparam logic [11:0] CSR_MHPMEVENT_BASE   = 12'h320;
   localparam logic [11:0] CSR_MCOUNTEREN       = 12'h306;
   localparam logic [11:0] CSR_SCOUNTEREN       = 12'h106;
   localparam logic [11:0] CSR_MCOUNTOVF        = 12'h7C0;

   // Select values 1..num_events are meaningful, so 0..num_events must fit.
   function automatic int evsel_width(input int num_events);
      return $clog2(num_events + 1);
   endfunction

endpackage

// File: rtl/csr_counter_cell.sv
// One COUNTER_WIDTH counter with split low/high write and gated increment.
// Wrap detection output exists only when CSR_COUNTER_OVERFLOW_EN is defined.
module csr_counter_cell
   import csr_counter_bank_pkg::*;
#(
   parameter int COUNTER_WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     i_wr_lo,
   input  logic                     i_wr_hi,
   input  logic [31:0]              i_wdata,
   input  logic                     i_inc,
   input  logic                     i_inhibit,
   output logic [COUNTER_WIDTH-1:0] o_value
`ifdef CSR_COUNTER_OVERFLOW_EN
   , output logic                   o_wrap
`endif
);

   logic [COUNTER_WIDTH-1:0] r_cnt;
   logic                     w_step;

   assign w_step  = i_inc && !i_inhibit;
   assign o_value = r_cnt;

   // A write on either half discards that cycle's increment entirely.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_cnt <= '0;
      end else if (i_wr_lo || i_wr_hi) begin
         if (i_wr_lo) r_cnt[31:0] <= i_wdata;
         if (i_wr_hi) r_cnt[COUNTER_WIDTH-1:32] <= i_wdata[COUNTER_WIDTH-33:0];
      end else if (w_step) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

`ifdef CSR_COUNTER_OVERFLOW_EN
   assign o_wrap = w_step && !(i_wr_lo || i_wr_hi) && (&r_cnt);
`endif

endmodule

// File: rtl/csr_counter_bank.sv
// Machine counter CSR bank: mcycle, minstret, hpm counters, selectors, enables.
// Define CSR_COUNTER_OVERFLOW_EN to add the mcountovf sticky register and overflowIrq.
module csr_counter_bank
   import csr_counter_bank_pkg::*;
#(
   parameter int NUM_COUNTERS  = 4,
   parameter int NUM_EVENTS    = 8,
   parameter int COUNTER_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [1:0]            privilege,
   input  logic                  readEnable,
   input  logic [11:0]           readAddr,
   output logic [31:0]           readValue,
   output logic                  readIllegal,
   input  logic                  writeEnable,
   input  logic [11:0]           writeAddr,
   input  logic [31:0]           writeValue,
   input  logic                  retire,
   input  logic [NUM_EVENTS-1:0] events,
   output logic                  overflowIrq
);

   localparam int          ES        = evsel_width(NUM_EVENTS);
   localparam logic [63:0] HPM64     = ((64'd1 << NUM_COUNTERS) - 64'd1) << 3;
   localparam logic [31:0] HPM_MASK  = HPM64[31:0];
   localparam logic [31:0] WARL_MASK = HPM_MASK | 32'h5;

   logic [31:0]       r_inhibit;
   logic [31:0]       r_mcen;
   logic [31:0]       r_scen;
   csr_counter_t      w_cnt   [0:31];
   logic [ES-1:0]     w_evsel [0:31];
   logic [NUM_EVENTS:0] w_ev_ext;
   logic [4:0]        w_ridx;

   assign w_ev_ext = {events, 1'b0};
   assign w_ridx   = readAddr[4:0];

`ifdef CSR_COUNTER_OVERFLOW_EN
   logic [31:0] w_wrap;
   logic [31:0] r_ovf;
   logic [31:0] w_ovf_clr;
`endif

   for (genvar i = 0; i < 32; i++) begin : g_cnt
      if (i == 0 || i == 2 || (i >= 3 && i < 3 + NUM_COUNTERS)) begin : g_impl
         localparam logic [11:0] A_LO = CSR_MHPMCOUNTER_BASE + 12'(i);
         localparam logic [11:0] A_HI = CSR_MHPMCOUNTERH_BASE + 12'(i);
         logic                     w_inc;
         logic [COUNTER_WIDTH-1:0] w_val;

         if (i == 0) begin : g_cycle
            assign w_inc      = 1'b1;
            assign w_evsel[i] = '0;
         end else if (i == 2) begin : g_instret
            assign w_inc      = retire;
            assign w_evsel[i] = '0;
         end else begin : g_hpm
            localparam logic [11:0] A_EV = CSR_MHPMEVENT_BASE + 12'(i);
            logic [ES-1:0] r_sel;
            always_ff @(posedge clk or negedge rstN) begin
               if (!rstN) r_sel <= '0;
               else if (writeEnable && writeAddr == A_EV) r_sel <= writeValue[ES-1:0];
            end
            // Out-of-range selects count nothing.
            assign w_inc = (r_sel != '0 && r_sel <= ES'(NUM_EVENTS)) ? w_ev_ext[r_sel] : 1'b0;
            assign w_evsel[i] = r_sel;
         end

         csr_counter_cell #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_cell (
            .clk       (clk),
            .rstN      (rstN),
            .i_wr_lo   (writeEnable && writeAddr == A_LO),
            .i_wr_hi   (writeEnable && writeAddr == A_HI),
            .i_wdata   (writeValue),
            .i_inc     (w_inc),
            .i_inhibit (r_inhibit[i]),
            .o_value   (w_val)
`ifdef CSR_COUNTER_OVERFLOW_EN
            , .o_wrap  (w_wrap[i])
`endif
         );
         assign w_cnt[i] = csr_counter_t'(w_val);
      end else begin : g_none
         assign w_cnt[i]   = '0;
         assign w_evsel[i] = '0;
`ifdef CSR_COUNTER_OVERFLOW_EN
         assign w_wrap[i]  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_inhibit <= '0;
         r_mcen    <= '0;
         r_scen    <= '0;
      end else if (writeEnable) begin
         case (writeAddr)
            CSR_MCOUNTINHIBIT: r_inhibit <= writeValue & WARL_MASK;
            CSR_MCOUNTEREN:    r_mcen    <= writeValue & WARL_MASK;
            CSR_SCOUNTEREN:    r_scen    <= writeValue & WARL_MASK;
            default: ;
         endcase
      end
   end

`ifdef CSR_COUNTER_OVERFLOW_EN
   assign w_ovf_clr = (writeEnable && writeAddr == CSR_MCOUNTOVF) ? writeValue : '0;

   // Set is OR-ed after the clear so a simultaneous wrap wins.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_ovf <= '0;
      else       r_ovf <= ((r_ovf & ~w_ovf_clr) | w_wrap) & HPM_MASK;
   end

   assign overflowIrq = |r_ovf;
`else
   assign overflowIrq = 1'b0;
`endif

   always_comb begin
      readValue   = '0;
      readIllegal = 1'b0;
      if (readEnable) begin
         if (readAddr[11:8] == 4'hB && readAddr[6:5] == 2'b00) begin
            if (w_ridx == 5'd1 || privilege != PRIV_M) readIllegal = 1'b1;
            else readValue = readAddr[7] ? w_cnt[w_ridx][63:32] : w_cnt[w_ridx][31:0];
         end else if (readAddr[11:8] == 4'hC && readAddr[6:5] == 2'b00) begin
            if (w_ridx == 5'd1) readIllegal = 1'b1;
            else if (privilege == PRIV_U && !(r_mcen[w_ridx] && r_scen[w_ridx])) readIllegal = 1'b1;
            else if (privilege != PRIV_M && !r_mcen[w_ridx]) readIllegal = 1'b1;
            else readValue = readAddr[7] ? w_cnt[w_ridx][63:32] : w_cnt[w_ridx][31:0];
         end else if (readAddr[11:5] == CSR_MHPMEVENT_BASE[11:5]) begin
            if (privilege != PRIV_M) readIllegal = 1'b1;
            else if (w_ridx == 5'd0) readValue = r_inhibit;
            else if (w_ridx < 5'd3) readIllegal = 1'b1;
            else readValue = 32'(w_evsel[w_ridx]);
         end else if (readAddr == CSR_MCOUNTEREN) begin
            if (privilege != PRIV_M) readIllegal = 1'b1;
            else readValue = r_mcen;
         end else if (readAddr == CSR_SCOUNTEREN) begin
            if (privilege != PRIV_M && privilege != PRIV_S) readIllegal = 1'b1;
            else readValue = r_scen;
`ifdef CSR_COUNTER_OVERFLOW_EN
         end else if (readAddr == CSR_MCOUNTOVF) begin
            if (privilege != PRIV_M) readIllegal = 1'b1;
            else readValue = r_ovf;
`endif
         end else begin
            readIllegal = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank: reads push expectations, a negedge monitor checks.
// Build with CSR_COUNTER_OVERFLOW_EN to exercise mcountovf expectations as well.
module tb_csr_counter_bank;

   localparam int N = 4;
   localparam int E = 8;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  privilege;
   logic        readEnable;
   logic [11:0] readAddr;
   logic [31:0] readValue;
   logic        readIllegal;
   logic        writeEnable;
   logic [11:0] writeAddr;
   logic [31:0] writeValue;
   logic        retire;
   logic [E-1:0] events;
   logic        overflowIrq;

   csr_counter_bank #(.NUM_COUNTERS(N), .NUM_EVENTS(E), .COUNTER_WIDTH(64)) dut (
      .clk         (clk),
      .rstN        (rstN),
      .privilege   (privilege),
      .readEnable  (readEnable),
      .readAddr    (readAddr),
      .readValue   (readValue),
      .readIllegal (readIllegal),
      .writeEnable (writeEnable),
      .writeAddr   (writeAddr),
      .writeValue  (writeValue),
      .retire      (retire),
      .events      (events),
      .overflowIrq (overflowIrq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] val;
      logic        ill;
      logic        irq;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_irq = 1'b0;

   // Monitor: every presented read is checked against the oldest expectation.
   always @(negedge clk) begin
      if (readEnable) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_read: got val=%h ill=%b, required no read", readValue, readIllegal);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (readValue !== e.val || readIllegal !== e.ill || overflowIrq !== e.irq) begin
               n_bad++;
               $display("FAIL %s: got val=%h ill=%b irq=%b, required val=%h ill=%b irq=%b",
                        e.name, readValue, readIllegal, overflowIrq, e.val, e.ill, e.irq);
            end
         end
      end
   end

   // Both tasks start and end 1 time unit after a rising edge.
   task automatic rd(input string nm, input logic [11:0] a, input logic [1:0] p,
                     input logic [31:0] v, input logic ill);
      exp_t e;
      e.name = nm; e.val = v; e.ill = ill; e.irq = exp_irq;
      q.push_back(e);
      readEnable = 1'b1; readAddr = a; privilege = p;
      @(posedge clk); #1;
      readEnable = 1'b0; privilege = 2'd3;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] v);
      writeEnable = 1'b1; writeAddr = a; writeValue = v;
      @(posedge clk); #1;
      writeEnable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstN = 1'b1; privilege = 2'd3; readEnable = 1'b0; readAddr = '0;
      writeEnable = 1'b0; writeAddr = '0; writeValue = '0; retire = 1'b0; events = '0;
      #1 rstN = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rstN = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // Reset state and free-running cycle count
      rd("mcycle_10",   12'hB00, 2'd3, 32'd10, 1'b0);
      rd("mcycleh_0",   12'hB80, 2'd3, 32'd0,  1'b0);
      rd("minstret_0",  12'hB02, 2'd3, 32'd0,  1'b0);
      rd("hpm3_0",      12'hB03, 2'd3, 32'd0,  1'b0);
      rd("inhibit_0",   12'h320, 2'd3, 32'd0,  1'b0);
      rd("mcounteren_0",12'h306, 2'd3, 32'd0,  1'b0);
      rd("scounteren_0",12'h106, 2'd3, 32'd0,  1'b0);

      // Half writes and wrap on event
      wr(12'hB83, 32'hFFFF_FFFF);
      wr(12'hB03, 32'hFFFF_FFFF);
      wr(12'h323, 32'd1);
      rd("hpm3_lo_ones", 12'hB03, 2'd3, 32'hFFFF_FFFF, 1'b0);
      rd("hpm3_hi_ones", 12'hB83, 2'd3, 32'hFFFF_FFFF, 1'b0);
      events = 8'h01;
      @(posedge clk); #1;
      events = 8'h00;
`ifdef CSR_COUNTER_OVERFLOW_EN
      exp_irq = 1'b1;
`endif
      rd("hpm3_lo_wrap", 12'hB03, 2'd3, 32'd0, 1'b0);
      rd("hpm3_hi_wrap", 12'hB83, 2'd3, 32'd0, 1'b0);
`ifdef CSR_COUNTER_OVERFLOW_EN
      rd("mcountovf_set", 12'h7C0, 2'd3, 32'h8, 1'b0);
      wr(12'h7C0, 32'h8);
      exp_irq = 1'b0;
      rd("mcountovf_clr", 12'h7C0, 2'd3, 32'h0, 1'b0);
`else
      rd("mcountovf_absent", 12'h7C0, 2'd3, 32'h0, 1'b1);
`endif

      // minstret counting and write/increment collision
      retire = 1'b1;
      repeat (3) @(posedge clk);
      #1 retire = 1'b0;
      rd("minstret_3", 12'hB02, 2'd3, 32'd3, 1'b0);
      retire = 1'b1;
      wr(12'hB02, 32'd5);
      retire = 1'b0;
      rd("collision_5", 12'hB02, 2'd3, 32'd5, 1'b0);

      // Privilege gating of shadows and machine range
      wr(12'h320, 32'h1);
      wr(12'hB00, 32'h0000_1234);
      wr(12'h306, 32'h1);
      rd("u_cycle_noscen", 12'hC00, 2'd0, 32'd0, 1'b1);
      wr(12'h106, 32'h1);
      rd("u_cycle_ok",     12'hC00, 2'd0, 32'h1234, 1'b0);
      rd("u_cycleh_ok",    12'hC80, 2'd0, 32'd0, 1'b0);
      rd("s_cycle_ok",     12'hC00, 2'd1, 32'h1234, 1'b0);
      rd("s_mcycle_ill",   12'hB00, 2'd1, 32'd0, 1'b1);
      rd("u_time_ill",     12'hC01, 2'd0, 32'd0, 1'b1);
      rd("u_hpm3_ill",     12'hC03, 2'd0, 32'd0, 1'b1);
      rd("u_scen_ill",     12'h106, 2'd0, 32'd0, 1'b1);
      rd("s_scen_ok",      12'h106, 2'd1, 32'h1, 1'b0);

      // Inhibit, WARL masks and unimplemented indices
      wr(12'h320, 32'hFFFF_FFFF);
      rd("inhibit_warl", 12'h320, 2'd3, 32'h0000_007D, 1'b0);
      events = 8'hFF; retire = 1'b1;
      repeat (20) @(posedge clk);
      #1 events = 8'h00; retire = 1'b0;
      rd("frozen_hpm3",     12'hB03, 2'd3, 32'd0, 1'b0);
      rd("frozen_minstret", 12'hB02, 2'd3, 32'd5, 1'b0);
      rd("frozen_mcycle",   12'hB00, 2'd3, 32'h1234, 1'b0);
      wr(12'h324, 32'hFF);
      rd("evsel4_warl", 12'h324, 2'd3, 32'hF, 1'b0);
      wr(12'h320, 32'h0);
      events = 8'hFF;
      repeat (5) @(posedge clk);
      #1 events = 8'h00;
      rd("hpm3_5",        12'hB03, 2'd3, 32'd5, 1'b0);
      rd("hpm4_badsel_0", 12'hB04, 2'd3, 32'd0, 1'b0);
      wr(12'hB07, 32'd5);
      rd("unimpl_hpm7_0", 12'hB07, 2'd3, 32'd0, 1'b0);
      rd("unimpl_ev7_0",  12'h327, 2'd3, 32'd0, 1'b0);
      rd("unmapped_321",  12'h321, 2'd3, 32'd0, 1'b1);
      rd("unmapped_b01",  12'hB01, 2'd3, 32'd0, 1'b1);

      // Asynchronous reset between edges
      rstN = 1'b0;
      rd("rst_hpm3",   12'hB03, 2'd3, 32'd0, 1'b0);
      rd("rst_scen",   12'h106, 2'd3, 32'd0, 1'b0);
      rstN = 1'b1;
      rd("post_mcycle", 12'hB00, 2'd3, 32'd0, 1'b0);
      rd("post_evsel3", 12'h323, 2'd3, 32'd0, 1'b0);
      rd("post_mcen",   12'h306, 2'd3, 32'd0, 1'b0);

      repeat (3) @(posedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
